// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: types and constants shared by the data-memory side of the MIPS datapath.
//   MEM_AW  : byte-address width of the 128-byte data memory
//   WORD_IW : word-index width (byte address minus the two byte-offset bits)
//   MEM_DW  : data width
package mips_mem_pkg;
    localparam int MEM_AW  = 7;
    localparam int WORD_IW = MEM_AW - 2;
    localparam int MEM_DW  = 32;

    typedef struct packed {
        logic [WORD_IW-1:0] index;
        logic [MEM_DW-1:0]  data;
    } sb_entry_t;

    typedef enum logic [1:0] {REQ_IDLE, REQ_LOAD, REQ_STORE} req_kind_e;
endpackage

// File: rtl/sb_forward_match.sv
// sb_forward_match: youngest-match search over the store-buffer FIFO.
//   index_i/data_i : per-slot word index and data
//   head_i/count_i : oldest slot and number of valid slots
//   key_i          : word index being loaded
//   hit_o/data_o   : some valid slot matched / data of the youngest match
module sb_forward_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = WORD_IW,
    parameter int DW    = MEM_DW
) (
    input  logic [DEPTH-1:0][IW-1:0]   index_i,
    input  logic [DEPTH-1:0][DW-1:0]   data_i,
    input  logic [$clog2(DEPTH)-1:0]   head_i,
    input  logic [$clog2(DEPTH+1)-1:0] count_i,
    input  logic [IW-1:0]              key_i,
    output logic                       hit_o,
    output logic [DW-1:0]              data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        logic [PW-1:0] p;
        p      = '0;
        hit_o  = 1'b0;
        data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            p = head_i + PW'(k);
            if (CW'(k) < count_i && index_i[p] == key_i) begin
                hit_o  = 1'b1;
                data_o = data_i[p];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the MIPS datapath and data memory.
//   cpu_*  : load/store requests from the CPU, cpu_rdata is combinational
//   flush  : level-sensitive drain request, stall holds the CPU
//   empty  : no stores pending
//   mem_*  : DataMemory port, shared by loads and store retirement
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_write,
    input  logic          cpu_read,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          flush,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write,
    output logic          mem_read,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int IW = AW - 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][IW-1:0] idx_q;
    logic [DEPTH-1:0][DW-1:0] dat_q;
    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    req_kind_e                kind;
    logic                     full, enq, drain, hit;
    logic [DW-1:0]            fwd_data;

    // A simultaneous read and write is treated as a read.
    assign kind  = cpu_read ? REQ_LOAD : (cpu_write ? REQ_STORE : REQ_IDLE);
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign enq   = kind == REQ_STORE && !full && !flush;
    // Loads own the memory port; every other non-enqueue cycle retires the head.
    assign drain = kind != REQ_LOAD && !empty && !enq;
    assign stall = (flush && !empty) || (kind == REQ_STORE && full);

    assign mem_write = drain;
    assign mem_read  = reset && kind == REQ_LOAD;
    assign mem_addr  = drain ? {idx_q[head_q], 2'b00} : cpu_addr;
    assign mem_wdata = drain ? dat_q[head_q] : cpu_wdata;
    assign cpu_rdata = hit ? fwd_data : mem_rdata;

    assign head_d  = head_q + PW'(drain);
    assign tail_d  = tail_q + PW'(enq);
    assign count_d = count_q + CW'(enq) - CW'(drain);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            idx_q[tail_q] <= cpu_addr[AW-1:2];
            dat_q[tail_q] <= cpu_wdata;
        end
    end

    sb_forward_match #(.DEPTH(DEPTH), .IW(IW), .DW(DW)) u_match (
        .index_i (idx_q),
        .data_i  (dat_q),
        .head_i  (head_q),
        .count_i (count_q),
        .key_i   (cpu_addr[AW-1:2]),
        .hit_o   (hit),
        .data_o  (fwd_data)
    );
endmodule
